// File: rtl/jam_perm_search_if.sv
// -----------------------------------------------------------------------------
// jam_perm_search_if
// Bundles the run handshake, the cost-ROM port and the result bus of the
// jam_perm_search engine.
//
// Handshake: Start is a level request. The engine accepts it only on a rising
// CLK edge where it is idle or done, and it ignores Start while Busy is high.
// Valid rises when enumeration completes. Valid then stays high until the next
// accepted Start. MinCost, MatchCount and BestPerm are final whenever Valid is
// high. The ROM answers Cost for the presented W/J before the next rising edge.
//
// Signals:
//   Start      - run request (environment -> engine)
//   W, J       - worker / job index presented to the cost ROM (engine -> ROM)
//   Cost       - ROM data for W/J (ROM -> engine)
//   Busy       - enumeration in progress
//   Valid      - results valid
//   MinCost    - minimum total assignment cost
//   MatchCount - number of permutations at MinCost, saturating
//   BestPerm   - first optimal assignment, job of worker i at [3i+2:3i]
// Modports: master = engine side, slave = environment side.
// -----------------------------------------------------------------------------
interface jam_perm_search_if #(
    parameter int N      = 8,
    parameter int COST_W = 7,
    parameter int SUM_W  = 9,
    parameter int CNT_W  = 4
);
    logic              Start;
    logic [2:0]        W;
    logic [2:0]        J;
    logic [COST_W-1:0] Cost;
    logic              Busy;
    logic              Valid;
    logic [SUM_W-1:0]  MinCost;
    logic [CNT_W-1:0]  MatchCount;
    logic [3*N-1:0]    BestPerm;

    modport master (
        input  Start, Cost,
        output W, J, Busy, Valid, MinCost, MatchCount, BestPerm
    );

    modport slave (
        output Start, Cost,
        input  W, J, Busy, Valid, MinCost, MatchCount, BestPerm
    );
endinterface

// File: rtl/jam_perm_search.sv
// -----------------------------------------------------------------------------
// jam_perm_search
// Exhaustive one-to-one job assignment. The engine walks all N! permutations
// in lexicographic order. For each one it fetches N costs from an external
// ROM and accumulates them. It keeps the minimum total, the saturating count
// of permutations that reach it, and the first permutation that reached it.
//
// Ports:
//   CLK       - clock, rising edge
//   RST       - synchronous active-high reset; overrides Start
//   bus       - jam_perm_search_if.master (Start/Busy/Valid, ROM W/J/Cost,
//               results)
//   dbg_state - current FSM state (0 IDLE, 1 FETCH, 2 EVAL, 3 DONE)
// -----------------------------------------------------------------------------
module jam_perm_search #(
    parameter int N      = 8,
    parameter int COST_W = 7,
    parameter int SUM_W  = 9,
    parameter int CNT_W  = 4
) (
    input  logic                CLK,
    input  logic                RST,
    jam_perm_search_if.master   bus,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EVAL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // The permutation is held in a fixed 8-entry array, so 3-bit indices are
    // always exact. Only entries 0..N-1 are meaningful.
    logic [2:0]       perm_q   [8];
    logic [2:0]       swapped  [8];
    logic [2:0]       nxt_perm [8];
    logic [2:0]       w_q;
    logic [SUM_W-1:0] acc_q;
    logic [SUM_W-1:0] min_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3*N-1:0]   best_q;
    logic [3*N-1:0]   perm_flat;
    logic             valid_q;
    logic             has_pivot;
    logic [2:0]       pivot;
    logic [2:0]       succ;
    logic [3:0]       rev;
    logic             start_ok;

    function automatic logic [3*N-1:0] identity_flat();
        logic [3*N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[3*i +: 3] = 3'(i);
        return r;
    endfunction

    assign start_ok = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.Start;

    // Next lexicographic permutation. The pivot is the rightmost i with
    // p[i] < p[i+1]. The successor is the rightmost j > pivot with
    // p[j] > p[pivot]. Swap those two, then reverse the suffix after the
    // pivot. When no pivot exists, the current permutation is the descending
    // (last) one.
    always_comb begin
        has_pivot = 1'b0;
        pivot     = 3'd0;
        for (int i = 0; i < N - 1; i++) begin
            if (perm_q[3'(i)] < perm_q[3'(i + 1)]) begin
                has_pivot = 1'b1;
                pivot     = 3'(i);
            end
        end
        succ = pivot;
        for (int j = 0; j < N; j++) begin
            if ((3'(j) > pivot) && (perm_q[3'(j)] > perm_q[pivot])) succ = 3'(j);
        end
        swapped        = perm_q;
        swapped[pivot] = perm_q[succ];
        swapped[succ]  = perm_q[pivot];
        nxt_perm       = swapped;
        rev            = 4'd0;
        for (int k = 0; k < N; k++) begin
            if (3'(k) > pivot) begin
                // Mirror position k inside the suffix pivot+1 .. N-1.
                rev              = 4'(N) + {1'b0, pivot} - 4'(k);
                nxt_perm[3'(k)]  = swapped[rev[2:0]];
            end
        end
    end

    always_comb begin
        perm_flat = '0;
        for (int i = 0; i < N; i++) perm_flat[3*i +: 3] = perm_q[3'(i)];
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state and ROM-port outputs
    always_comb begin
        state_d  = state_q;
        bus.Busy = 1'b0;
        bus.W    = 3'd0;
        case (state_q)
            S_IDLE:  if (bus.Start) state_d = S_FETCH;
            S_FETCH: begin
                bus.Busy = 1'b1;
                bus.W    = w_q;
                if (w_q == 3'(N - 1)) state_d = S_EVAL;
            end
            S_EVAL: begin
                bus.Busy = 1'b1;
                state_d  = has_pivot ? S_FETCH : S_DONE;
            end
            S_DONE:  if (bus.Start) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
        bus.J = perm_q[bus.W];
    end

    // Datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            w_q     <= 3'd0;
            acc_q   <= '0;
            min_q   <= '1;
            cnt_q   <= '0;
            best_q  <= identity_flat();
            valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) perm_q[3'(i)] <= 3'(i);
        end else if (start_ok) begin
            w_q     <= 3'd0;
            acc_q   <= '0;
            min_q   <= '1;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) perm_q[3'(i)] <= 3'(i);
        end else if (state_q == S_FETCH) begin
            acc_q <= acc_q + SUM_W'(bus.Cost);
            w_q   <= (w_q == 3'(N - 1)) ? 3'd0 : w_q + 3'd1;
        end else if (state_q == S_EVAL) begin
            if (acc_q < min_q) begin
                min_q  <= acc_q;
                cnt_q  <= {{(CNT_W-1){1'b0}}, 1'b1};
                best_q <= perm_flat;
            end else if (acc_q == min_q) begin
                if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
            end
            acc_q <= '0;
            // The last permutation stays in place while the engine is done.
            if (has_pivot) perm_q <= nxt_perm;
            else           valid_q <= 1'b1;
        end
    end

    assign bus.Valid      = valid_q;
    assign bus.MinCost    = min_q;
    assign bus.MatchCount = cnt_q;
    assign bus.BestPerm   = best_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_jam_perm_search.sv
// -----------------------------------------------------------------------------
// tb_jam_perm_search
// Drives an N=3 engine and an N=4 engine from table-driven cost ROMs. The
// expected results come from a brute-force enumeration of all N^N index
// tuples. The tuples with distinct digits are exactly the permutations, and
// they occur in lexicographic order.
// -----------------------------------------------------------------------------
module tb_jam_perm_search;
    localparam int COST_W = 7;
    localparam int SUM_W  = 9;
    localparam int CNT_W  = 4;

    logic clk;
    logic rst3, rst4;
    logic start3, start4;
    logic [1:0] dbg3, dbg4;
    logic [COST_W-1:0] rom3 [64];
    logic [COST_W-1:0] rom4 [64];

    int checks   = 0;
    int failures = 0;
    logic mon_on = 1'b0;

    int         exp_min3, exp_cnt3, exp_min4, exp_cnt4;
    logic [8:0]  exp_best3;
    logic [11:0] exp_best4;

    jam_perm_search_if #(.N(3), .COST_W(COST_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) if3();
    jam_perm_search_if #(.N(4), .COST_W(COST_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) if4();

    assign if3.Start = start3;
    assign if4.Start = start4;
    assign if3.Cost  = rom3[{if3.W, if3.J}];
    assign if4.Cost  = rom4[{if4.W, if4.J}];

    jam_perm_search #(.N(3), .COST_W(COST_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) u3 (
        .CLK(clk), .RST(rst3), .bus(if3), .dbg_state(dbg3)
    );
    jam_perm_search #(.N(4), .COST_W(COST_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) u4 (
        .CLK(clk), .RST(rst4), .bus(if4), .dbg_state(dbg4)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Brute-force reference: walk every n-digit base-n tuple (worker 0 is the
    // most significant digit) and keep only tuples with distinct digits.
    task automatic model(input int n, input logic [COST_W-1:0] rom [64],
                         output int mn, output int cnt_sat, output int cnt_true,
                         output logic [23:0] best);
        int total, tuples, tmp, sum;
        int d [8];
        logic [7:0] used;
        logic ok;
        tuples = 1;
        for (int i = 0; i < n; i++) tuples *= n;
        mn = 1 << 30;
        cnt_true = 0;
        best = '0;
        for (int t = 0; t < tuples; t++) begin
            tmp = t;
            for (int w = n - 1; w >= 0; w--) begin
                d[w] = tmp % n;
                tmp  = tmp / n;
            end
            used = '0;
            ok = 1'b1;
            for (int w = 0; w < n; w++) begin
                if (used[d[w]]) ok = 1'b0;
                used[d[w]] = 1'b1;
            end
            if (ok) begin
                sum = 0;
                for (int w = 0; w < n; w++) sum += int'(rom[w*8 + d[w]]);
                total = sum;
                if (total < mn) begin
                    mn = total;
                    cnt_true = 1;
                    best = '0;
                    for (int w = 0; w < n; w++) best[3*w +: 3] = 3'(d[w]);
                end else if (total == mn) begin
                    cnt_true++;
                end
            end
        end
        cnt_sat = (cnt_true > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : cnt_true;
    endtask

    function automatic logic valid_of(input int sel);
        return (sel == 3) ? if3.Valid : if4.Valid;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 3) ? if3.Busy : if4.Busy;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 3) start3 = v;
        else          start4 = v;
    endtask

    // ---------------- driver ----------------
    // Starts a run and returns the number of edges from the accepting edge
    // to the edge where Valid rises. A pulse_at value >= 0 re-asserts Start
    // for one cycle while the engine is busy.
    task automatic run(input int sel, input int mn, input int cnt, input logic [23:0] best,
                       input int pulse_at, output int cyc);
        @(posedge clk); #1 set_start(sel, 1'b1);
        @(posedge clk); #1 set_start(sel, 1'b0);
        if (sel == 3) begin
            exp_min3 = mn; exp_cnt3 = cnt; exp_best3 = best[8:0];
        end else begin
            exp_min4 = mn; exp_cnt4 = cnt; exp_best4 = best[11:0];
        end
        check("valid_low_after_start", 32'(valid_of(sel)), 32'd0);
        check("busy_after_start", 32'(busy_of(sel)), 32'd1);
        cyc = 0;
        while (!valid_of(sel) && cyc < 2000) begin
            if (cyc == pulse_at) set_start(sel, 1'b1);
            @(posedge clk); #1;
            set_start(sel, 1'b0);
            cyc++;
        end
        check("run_completed", 32'(valid_of(sel)), 32'd1);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (mon_on && !rst3) begin
            check("n3_busy_valid_exclusive", 32'(if3.Busy && if3.Valid), 32'd0);
            if (!if3.Busy) check("n3_w_idle", 32'(if3.W), 32'd0);
            else           check("n3_w_range", 32'(if3.W < 3'd3), 32'd1);
            if (if3.Valid) begin
                check("n3_mincost", 32'(if3.MinCost), 32'(exp_min3));
                check("n3_matchcount", 32'(if3.MatchCount), 32'(exp_cnt3));
                check("n3_bestperm", 32'(if3.BestPerm), 32'(exp_best3));
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on && !rst4) begin
            check("n4_busy_valid_exclusive", 32'(if4.Busy && if4.Valid), 32'd0);
            if (!if4.Busy) check("n4_w_idle", 32'(if4.W), 32'd0);
            else           check("n4_w_range", 32'(if4.W < 3'd4), 32'd1);
            if (if4.Valid) begin
                check("n4_mincost", 32'(if4.MinCost), 32'(exp_min4));
                check("n4_matchcount", 32'(if4.MatchCount), 32'(exp_cnt4));
                check("n4_bestperm", 32'(if4.BestPerm), 32'(exp_best4));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int mn, cs, ct, cyc;
        logic [23:0] best;

        rst3 = 1'b1; rst4 = 1'b1; start3 = 1'b0; start4 = 1'b0;
        for (int i = 0; i < 64; i++) begin rom3[i] = '0; rom4[i] = '0; end
        exp_min3 = 0; exp_cnt3 = 0; exp_best3 = '0;
        exp_min4 = 0; exp_cnt4 = 0; exp_best4 = '0;
        repeat (3) @(posedge clk);
        #1 rst3 = 1'b0; rst4 = 1'b0;
        mon_on = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_w", 32'(if3.W), 32'd0);
        check("rst_j", 32'(if3.J), 32'd0);
        check("rst_busy", 32'(if3.Busy), 32'd0);
        check("rst_valid", 32'(if3.Valid), 32'd0);
        check("rst_mincost", 32'(if3.MinCost), 32'd511);
        check("rst_matchcount", 32'(if3.MatchCount), 32'd0);
        check("rst_bestperm3", 32'(if3.BestPerm), 32'h088);
        check("rst_bestperm4", 32'(if4.BestPerm), 32'h688);

        // Table A: Cost = 10*W + J, every permutation costs 33.
        for (int w = 0; w < 3; w++)
            for (int j = 0; j < 3; j++) rom3[w*8 + j] = 7'(10*w + j);
        model(3, rom3, mn, cs, ct, best);
        check("model_a_min", 32'(mn), 32'd33);
        check("model_a_cnt", 32'(cs), 32'd6);
        check("model_a_best", 32'(best), 32'h088);
        // A Start pulse in the middle of the run must not change anything.
        run(3, mn, cs, best, 7, cyc);
        check("a_latency", 32'(cyc), 32'd24);
        check("a_mincost", 32'(if3.MinCost), 32'd33);
        check("a_matchcount", 32'(if3.MatchCount), 32'd6);
        check("a_bestperm", 32'(if3.BestPerm), 32'h088);
        repeat (3) @(posedge clk);

        // Table B, restarted from DONE: cost 1 when J == (W+1)%3, else 9.
        for (int w = 0; w < 3; w++)
            for (int j = 0; j < 3; j++) rom3[w*8 + j] = (j == (w + 1) % 3) ? 7'd1 : 7'd9;
        model(3, rom3, mn, cs, ct, best);
        check("model_b_min", 32'(mn), 32'd3);
        check("model_b_cnt", 32'(cs), 32'd1);
        check("model_b_best", 32'(best), 32'h011);
        run(3, mn, cs, best, -1, cyc);
        check("b_latency", 32'(cyc), 32'd24);
        check("b_mincost", 32'(if3.MinCost), 32'd3);
        check("b_matchcount", 32'(if3.MatchCount), 32'd1);
        check("b_bestperm", 32'(if3.BestPerm), 32'h011);

        // Start and RST together: reset wins.
        @(posedge clk); #1 start3 = 1'b1; rst3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        check("rst_start_busy", 32'(if3.Busy), 32'd0);
        check("rst_start_valid", 32'(if3.Valid), 32'd0);
        check("rst_start_mincost", 32'(if3.MinCost), 32'd511);
        @(negedge clk);
        check("rst_start_still_idle", 32'(if3.Busy), 32'd0);

        // N=4, all zero costs: the count saturates at 15 (true count 24).
        model(4, rom4, mn, cs, ct, best);
        check("model_z_min", 32'(mn), 32'd0);
        check("model_z_cnt", 32'(cs), 32'd15);
        check("model_z_true", 32'(ct), 32'd24);
        check("model_z_best", 32'(best), 32'h688);
        run(4, mn, cs, best, 50, cyc);
        check("z_latency", 32'(cyc), 32'd120);
        check("z_mincost", 32'(if4.MinCost), 32'd0);
        check("z_matchcount", 32'(if4.MatchCount), 32'd15);

        // Reset in the middle of a run, 10 cycles after Start.
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst4 = 1'b1;
        @(posedge clk); #1 rst4 = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(if4.Busy), 32'd0);
        check("midrst_valid", 32'(if4.Valid), 32'd0);
        check("midrst_mincost", 32'(if4.MinCost), 32'd511);
        check("midrst_matchcount", 32'(if4.MatchCount), 32'd0);

        // Rerun with a table whose only optimum is the last permutation (3,2,1,0).
        for (int w = 0; w < 4; w++)
            for (int j = 0; j < 4; j++) rom4[w*8 + j] = (j == 3 - w) ? 7'd2 : 7'd7;
        model(4, rom4, mn, cs, ct, best);
        check("model_d_min", 32'(mn), 32'd8);
        check("model_d_cnt", 32'(cs), 32'd1);
        check("model_d_best", 32'(best), 32'h053);
        run(4, mn, cs, best, -1, cyc);
        check("d_latency", 32'(cyc), 32'd120);
        check("d_mincost", 32'(if4.MinCost), 32'd8);
        check("d_matchcount", 32'(if4.MatchCount), 32'd1);
        check("d_bestperm", 32'(if4.BestPerm), 32'h053);

        repeat (4) @(posedge clk);
        @(negedge clk);
        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/jam_perm_search.md
# jam_perm_search

Parametrised exhaustive job-assignment engine, the next generation of the 8x8 JAM block. It assigns N workers to N jobs one-to-one and enumerates all N! permutations in lexicographic order. For each permutation it fetches costs from an external cost ROM over the W/J/Cost port and reports the minimum total cost, the number of permutations achieving it, and the first optimal assignment. New versus JAM: N, cost width and result widths are parameters; a Start/Busy handshake allows repeated runs without reset; MatchCount saturates; the best assignment is exported.

## Interface
- N, default 8: workers = jobs; legal range 2..8.
- COST_W, default 7: width of one ROM cost entry.
- SUM_W, default 9: width of MinCost. Integrator guarantees N*max(Cost) < 2^SUM_W.
- CNT_W, default 4: width of MatchCount.

Ports:
- CLK  in  1: clock, rising-edge.
- RST  in  1: synchronous, active-high reset.
- Start  in  1: run request, sampled only in IDLE or DONE.
- W  out  3: worker index to ROM.
- J  out  3: job index to ROM.
- Cost  in  COST_W: ROM data for the current W/J, valid before the next rising edge.
- Busy  out  1: high while enumerating.
- Valid  out  1: results valid; held until the next accepted Start.
- MinCost  out  SUM_W: minimum total cost.
- MatchCount  out  CNT_W: permutations at MinCost, saturating.
- BestPerm  out  3*N: job of worker i at bits [3i+2:3i]; first optimal permutation in lexicographic order.

## Operation
- FSM states:
  - IDLE: on Start go to FETCH; else stay.
  - FETCH: N cycles, presenting W=0..N-1 with J=perm[W]; go to EVAL after W=N-1 is sampled.
  - EVAL: 1 cycle; go to FETCH, or to DONE if perm was the last (descending) permutation.
  - DONE: Valid=1; on Start go to FETCH.
- Start entry (IDLE or DONE) performs, in one edge:
  - perm := identity (0,1,..,N-1);
  - MinCost := all ones;
  - MatchCount := 0;
  - Valid := 0;
  - acc := 0.
- FETCH: at each edge, acc += Cost (zero-extended to SUM_W, no wrap by constraint).
- EVAL: total = acc.
  - If total < MinCost: MinCost := total, MatchCount := 1, BestPerm := perm.
  - Else if total == MinCost: MatchCount := MatchCount+1, saturating at 2^CNT_W-1.
  - Then clear acc and advance perm by the standard next-permutation step (pivot, swap, suffix reversal), computed combinationally in this cycle.
- Busy = 1 in FETCH and EVAL only.
- Start is ignored while Busy.
- W/J: W=0 and J=perm[0] outside FETCH.

## Timing
- Reset values: W=0, J=0, Busy=0, Valid=0, MinCost=all ones, MatchCount=0, BestPerm=identity; state IDLE.
- Start sampled high at edge k:
  - Cost for permutation p (0-based) is sampled at edges k+p(N+1)+1 .. k+p(N+1)+N.
  - EVAL for p occurs at edge k+(p+1)(N+1).
  - Valid rises at edge k+N!(N+1): 24 cycles for N=3; 362880 for N=8.
- Outputs are registered. MinCost, MatchCount and BestPerm update only at EVAL edges and are final when Valid=1.
- RST mid-run takes priority over everything: next cycle all outputs are at reset values, state IDLE, no Valid.
- Start and RST high together: reset wins.

## Test plan
- N=3, Cost = 10*W+J: Start -> Valid at k+24; MinCost=33, MatchCount=6 (every permutation costs 33); BestPerm=identity (0,1,2).
- N=3, Cost=1 when J==(W+1)%3, else 9: MinCost=3, MatchCount=1, BestPerm = worker0->1, worker1->2, worker2->0.
- N=4, CNT_W=4, all costs 0: MinCost=0, MatchCount=15 (saturated, true count 24), Valid at k+120.
- N=8, COST_W=7, SUM_W=9, JAM-style cost table: MinCost and MatchCount match the golden file; Valid at k+362880.
- Reset mid-run: assert RST at cycle 10 of an N=4 run -> next cycle Busy=0, Valid=0, MinCost=511; a later Start completes with correct results.
- Restart and ignored Start:
  - Start pulsed while Busy -> no effect on results or timing.
  - Start in DONE with a new table -> Valid drops next cycle, new results after a full run.
